axi_rd_arbiter: RTL

- Stateful read-channel arbiter sharing one AXI master read port between the instruction cache and the data cache.
- Each requester's AR request is registered. The grant is held for the whole transaction, from AR issue to the final R beat, so R beats are never mis-steered between requesters.
- Uses round-robin arbitration and checks beat counts against rlast.
- Sits between the two caches and the CPU's top-level AXI interface, replacing purely combinational read muxing.

---
 rtl/axi_rd_arbiter_pkg.sv | 20 ++
 rtl/axi_rd_arbiter_rr_arb2.sv | 22 ++
 rtl/axi_rd_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  localparam logic [2:0] ARSIZE_WORD = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  localparam logic [3:0] INST_ID_DEF = 4'h0;
  localparam logic [3:0] DATA_ID_DEF = 4'h1;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last time wins.
module rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_sel_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_sel_o   = SEL_INST;
    case (req_i)
      2'b01:   gnt_sel_o = SEL_INST;
      2'b10:   gnt_sel_o = SEL_DATA;
      2'b11:   gnt_sel_o = ~last_grant_i;
      default: gnt_sel_o = SEL_INST;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master between inst and data caches; grant held from AR
// issue to the final R beat, with beat-count/rid checking into a sticky err.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned     ADDR_W  = 32,
  parameter int unsigned     DATA_W  = 32,
  parameter int unsigned     LEN_W   = 8,
  parameter int unsigned     ID_W    = 4,
  parameter logic [ID_W-1:0] INST_ID = ID_W'(INST_ID_DEF),
  parameter logic [ID_W-1:0] DATA_ID = ID_W'(DATA_ID_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_araddr,
  input  logic [LEN_W-1:0]  inst_arlen,
  input  logic [1:0]        inst_arburst,
  input  logic              inst_arvalid,
  output logic              inst_arready,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_rlast,
  output logic              inst_rvalid,
  input  logic              inst_rready,
  input  logic [ADDR_W-1:0] data_araddr,
  input  logic [LEN_W-1:0]  data_arlen,
  input  logic [1:0]        data_arburst,
  input  logic              data_arvalid,
  output logic              data_arready,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_rlast,
  output logic              data_rvalid,
  input  logic              data_rready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              err
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              gnt_valid, gnt_sel;
  logic              unused_rresp;

  assign unused_rresp = ^rresp;

  rr_arb2 u_rr_arb2 (
    .req_i        ({data_arvalid, inst_arvalid}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_sel_o    (gnt_sel)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arburst_d    = arburst_q;
    arid_d       = arid_q;
    beat_cnt_d   = beat_cnt_q;
    inst_arready = 1'b0;
    data_arready = 1'b0;
    rready       = 1'b0;
    inst_rvalid  = 1'b0;
    inst_rdata   = '0;
    inst_rlast   = 1'b0;
    data_rvalid  = 1'b0;
    data_rdata   = '0;
    data_rlast   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Suppress the accept while in reset so a requester never sees a lost handshake.
        if (gnt_valid && !rst) begin
          inst_arready = (gnt_sel == SEL_INST);
          data_arready = (gnt_sel == SEL_DATA);
          owner_d      = gnt_sel;
          last_grant_d = gnt_sel;
          beat_cnt_d   = '0;
          state_d      = ST_AR;
          if (gnt_sel == SEL_DATA) begin
            araddr_d  = data_araddr;
            arlen_d   = data_arlen;
            arburst_d = data_arburst;
            arid_d    = DATA_ID;
          end else begin
            araddr_d  = inst_araddr;
            arlen_d   = inst_arlen;
            arburst_d = inst_arburst;
            arid_d    = INST_ID;
          end
        end
      end
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (owner_q == SEL_DATA) begin
          rready      = data_rready;
          data_rvalid = rvalid;
          data_rdata  = rdata;
          data_rlast  = rlast;
        end else begin
          rready      = inst_rready;
          inst_rvalid = rvalid;
          inst_rdata  = rdata;
          inst_rlast  = rlast;
        end
        if (rvalid && rready) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (rid != arid_q) err_d = 1'b1;
          // beat_cnt_q is the index of the current beat, so the final beat matches arlen.
          if (rlast) begin
            state_d = ST_IDLE;
            if (beat_cnt_q != arlen_q) err_d = 1'b1;
          end else if (beat_cnt_q == arlen_q) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= SEL_INST;
      last_grant_q <= SEL_DATA;
      err_q        <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arburst_q    <= '0;
      arid_q       <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arburst_q    <= arburst_d;
      arid_q       <= arid_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign arvalid = (state_q == ST_AR);
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arburst = arburst_q;
  assign arid    = arid_q;
  assign arsize  = ARSIZE_WORD;
  assign err     = err_q;

endmodule
